// File: rtl/fetch_unit.sv
// Instruction fetch front end: a credit-limited request stream into IMEM and
// an in-order {pc, instr} queue toward decode. Redirects flush the queue and
// turn every outstanding request into one whose response is dropped.
module fetch_unit #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  output logic        IMEM_req_valid,
  output logic [31:0] IMEM_req_addr,
  input  logic        IMEM_req_ready,
  input  logic        IMEM_resp_valid,
  input  logic [31:0] IMEM_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_PC,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] instruction,
  output logic [31:0] PC
);
  localparam int          CW  = $clog2(QUEUE_DEPTH + 1);
  localparam int          AW  = $clog2(QUEUE_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_live;
  logic [CW-1:0] r_drop;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_q_pc    [QUEUE_DEPTH];
  logic [31:0]   r_q_instr [QUEUE_DEPTH];

  logic [CW+1:0] w_inflight;
  logic          w_accept;
  logic          w_push;
  logic          w_drop_resp;
  logic          w_pop;
  logic [31:0]   w_resp_pc;
  logic          w_unused;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == AW'(QUEUE_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Queue entries plus every request still in flight share one credit pool,
  // so a response always finds a free slot.
  assign w_inflight  = (CW+2)'(r_count) + (CW+2)'(r_live) + (CW+2)'(r_drop);
  assign IMEM_req_valid = !SYS_reset && !redirect_valid &&
                          (w_inflight < (CW+2)'(QUEUE_DEPTH));
  assign IMEM_req_addr  = r_fetch_pc;
  assign w_accept    = IMEM_req_valid && IMEM_req_ready;
  assign w_drop_resp = IMEM_resp_valid && (r_drop != '0);
  assign w_push      = IMEM_resp_valid && (r_drop == '0) && !redirect_valid;
  assign w_pop       = fetch_valid && fetch_ready && !redirect_valid;
  // Kept requests since the last redirect are consecutive words ending just
  // below fetch_pc, so the oldest one sits live_cnt words back.
  assign w_resp_pc   = r_fetch_pc - (32'(r_live) << 2);
  assign w_unused    = ^redirect_PC[1:0];

  assign fetch_valid = !SYS_reset && (r_count != '0);
  assign instruction = fetch_valid ? r_q_instr[r_rd_ptr] : NOP;
  assign PC          = fetch_valid ? r_q_pc[r_rd_ptr]    : 32'h0;

  // Control state: fetch pointer, credit counters and queue pointers.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_live     <= '0;
      r_drop     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_PC[31:2], 2'b00};
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_live     <= '0;
      r_drop     <= r_drop + r_live - CW'(IMEM_resp_valid);
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
      r_live  <= r_live + CW'(w_accept) - CW'(w_push);
      r_drop  <= r_drop - CW'(w_drop_resp);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
    end
  end

  // Queue payload; contents only matter when count says so, hence no reset.
  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset && w_push) begin
      r_q_pc[r_wr_ptr]    <= w_resp_pc;
      r_q_instr[r_wr_ptr] <= IMEM_resp_data;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order latency memory drives IMEM,
// and a queue-based reference model tracks what the consumer must see.
module tb_fetch_unit;
  localparam int          D   = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        SYS_reset, IMEM_req_valid, IMEM_req_ready, IMEM_resp_valid;
  logic [31:0] IMEM_req_addr, IMEM_resp_data, redirect_PC, instruction, PC;
  logic        redirect_valid, fetch_valid, fetch_ready;

  always #5 clk = ~clk;

  fetch_unit #(.QUEUE_DEPTH(D), .RESET_PC(RPC)) dut (
    .SYS_clk(clk), .SYS_reset(SYS_reset),
    .IMEM_req_valid(IMEM_req_valid), .IMEM_req_addr(IMEM_req_addr),
    .IMEM_req_ready(IMEM_req_ready), .IMEM_resp_valid(IMEM_resp_valid),
    .IMEM_resp_data(IMEM_resp_data), .redirect_valid(redirect_valid),
    .redirect_PC(redirect_PC), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .instruction(instruction), .PC(PC)
  );

  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  typedef struct { logic [31:0] pc; bit keep; } out_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;

  ent_t        q[$];   // expected fetch queue
  out_t        os[$];  // expected outstanding requests, oldest first
  mem_t        mq[$];  // memory pipeline
  logic [31:0] m_pc;
  int          cyc, n_vec, n_bad, n_acc;
  int          k_fr, k_mr, k_rd, k_rst, k_lmin, k_lmax;
  bit          force_rst, force_rd;
  logic [31:0] force_tgt;
  logic [31:0] s_addr, s_pc;
  bit          s_rv, s_fv;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    bit          resp, exp_rv, exp_fv, acc;
    out_t        o;
    logic [31:0] e_ins, e_pc;
    @(negedge clk);
    SYS_reset      = force_rst || ($urandom_range(999) < k_rst);
    fetch_ready    = ($urandom_range(99) < k_fr);
    IMEM_req_ready = ($urandom_range(99) < k_mr);
    if (force_rd) begin
      redirect_valid = 1'b1;
      redirect_PC    = force_tgt;
      force_rd       = 1'b0;
    end else begin
      redirect_valid = ($urandom_range(99) < k_rd);
      redirect_PC    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                : $urandom;
    end
    if (SYS_reset) mq.delete();
    resp = !SYS_reset && (mq.size() > 0) && (mq[0].due <= cyc);
    IMEM_resp_valid = resp;
    IMEM_resp_data  = resp ? memf(mq[0].addr) : $urandom;
    #2;
    exp_rv = !SYS_reset && !redirect_valid && (q.size() + os.size() < D);
    exp_fv = !SYS_reset && (q.size() > 0);
    e_ins  = exp_fv ? q[0].ins : NOP;
    e_pc   = exp_fv ? q[0].pc  : 32'h0;
    chk("req_valid", 32'(IMEM_req_valid), 32'(exp_rv));
    if (!SYS_reset) chk("req_addr", IMEM_req_addr, m_pc);
    chk("fetch_valid", 32'(fetch_valid), 32'(exp_fv));
    chk("instruction", instruction, e_ins);
    chk("pc", PC, e_pc);
    s_rv = IMEM_req_valid; s_addr = IMEM_req_addr; s_fv = fetch_valid; s_pc = PC;
    // memory side follows what the DUT actually drives
    if (resp) void'(mq.pop_front());
    if (!SYS_reset && IMEM_req_valid && IMEM_req_ready) begin
      n_acc++;
      mq.push_back('{addr: IMEM_req_addr, due: cyc + $urandom_range(k_lmax, k_lmin)});
    end
    // reference model
    if (SYS_reset) begin
      q.delete(); os.delete(); m_pc = RPC;
    end else if (redirect_valid) begin
      if (resp && os.size() > 0) void'(os.pop_front());
      foreach (os[i]) os[i].keep = 1'b0;
      q.delete();
      m_pc = {redirect_PC[31:2], 2'b00};
    end else begin
      acc = exp_rv && IMEM_req_ready;
      if (exp_fv && fetch_ready) void'(q.pop_front());
      if (resp && os.size() > 0) begin
        o = os.pop_front();
        if (o.keep) q.push_back('{pc: o.pc, ins: memf(o.pc)});
      end
      if (acc) begin
        os.push_back('{pc: m_pc, keep: 1'b1});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic knobs(input int fr, input int mr, input int rd, input int rs,
                       input int lmin, input int lmax);
    k_fr = fr; k_mr = mr; k_rd = rd; k_rst = rs; k_lmin = lmin; k_lmax = lmax;
  endtask

  task automatic reset2();
    force_rst = 1'b1; step(); step(); force_rst = 1'b0;
  endtask

  initial begin
    SYS_reset = 1'b1; IMEM_req_ready = 1'b0; IMEM_resp_valid = 1'b0;
    IMEM_resp_data = '0; redirect_valid = 1'b0; redirect_PC = '0; fetch_ready = 1'b0;
    cyc = 0; n_vec = 0; n_bad = 0; n_acc = 0; m_pc = RPC;
    force_rst = 1'b0; force_rd = 1'b0; force_tgt = '0;
    knobs(100, 100, 0, 0, 1, 1);
    reset2();

    // streaming: addresses 0,4,8 then first instruction at PC 0
    step(); chk("stream_a0", s_addr, 32'h0); chk("stream_v0", 32'(s_rv), 32'd1);
    step(); chk("stream_a1", s_addr, 32'h4); chk("stream_fv1", 32'(s_fv), 32'd0);
    step(); chk("stream_a2", s_addr, 32'h8); chk("stream_fv2", 32'(s_fv), 32'd1);
    chk("stream_pc2", s_pc, 32'h0);
    repeat (10) step();

    // consumer stalled: exactly D requests, then full and quiet
    reset2();
    knobs(0, 100, 0, 0, 1, 1);
    n_acc = 0;
    repeat (12) step();
    chk("full_reqs", 32'(n_acc), 32'(D));
    chk("full_req_valid", 32'(s_rv), 32'd0);
    chk("full_head_pc", s_pc, 32'h0);

    // memory stalled with a request pending
    knobs(100, 0, 0, 0, 1, 1);
    repeat (3) step();
    knobs(100, 100, 0, 0, 1, 1);
    repeat (4) step();

    // redirect with two late responses in flight
    knobs(0, 100, 0, 0, 3, 3);
    reset2();
    step(); step();
    force_rd = 1'b1; force_tgt = 32'h0000_0100;
    step();
    knobs(100, 100, 0, 0, 3, 3);
    repeat (10) step();

    // redirect to an unaligned top-of-memory target and wrap
    knobs(100, 100, 0, 0, 1, 1);
    reset2();
    step(); step();
    force_rd = 1'b1; force_tgt = 32'hFFFF_FFFE;
    step();
    step(); chk("wrap_hi", s_addr, 32'hFFFF_FFFC);
    step(); chk("wrap_lo", s_addr, 32'h0000_0000);
    repeat (5) step();

    // random traffic
    knobs(70, 70, 6, 3, 1, 4);
    repeat (3000) step();
    knobs(30, 90, 10, 2, 1, 2);
    repeat (2000) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
